// File: rtl/unibus_pkg.sv
// Shared Unibus arbitration types: FSM states, grant-select codes and request helpers.
package unibus_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    GRANT,
    SACKED,
    MASTER
  } arb_state_t;

  // Select codes: BR levels use their own level number, NPR uses 0.
  localparam logic [2:0] SEL_NPR = 3'd0;
  localparam logic [2:0] SEL_BR4 = 3'd4;
  localparam logic [2:0] SEL_BR5 = 3'd5;
  localparam logic [2:0] SEL_BR6 = 3'd6;
  localparam logic [2:0] SEL_BR7 = 3'd7;

  function automatic logic req_live(input logic [2:0] sel,
                                    input logic [7:4] br,
                                    input logic       npr);
    if (sel == SEL_NPR)
      return npr;
    return br[{1'b1, sel[1:0]}];
  endfunction

  // One-hot BG vector (bit 0 = BG4) for a BR select code.
  function automatic logic [3:0] grant_vec(input logic [2:0] sel);
    return 4'b0001 << sel[1:0];
  endfunction

endpackage

// File: rtl/unibus_prio_sel.sv
// Combinational Unibus request selector: NPR first, then highest BR above processor priority.
module unibus_prio_sel
  import unibus_pkg::*;
(
  input  logic [7:4] br,
  input  logic       npr,
  input  logic [2:0] cpu_prio,
  input  logic       cpu_br_ok,
  output logic       valid,
  output logic [2:0] sel
);

  always_comb begin
    valid = 1'b0;
    sel   = SEL_NPR;
    if (npr) begin
      valid = 1'b1;
      sel   = SEL_NPR;
    end else if (cpu_br_ok) begin
      // Ascending scan: the last hit is the highest eligible level.
      for (int unsigned l = 4; l <= 7; l++) begin
        if (br[l] && (3'(l) > cpu_prio)) begin
          valid = 1'b1;
          sel   = 3'(l);
        end
      end
    end
  end

endmodule

// File: rtl/unibus_arb.sv
// Unibus bus-grant arbiter: selects BR/NPR winner, drives BG/NPG and tracks SACK/BBSY.
module unibus_arb
  import unibus_pkg::*;
#(
  parameter int unsigned BG_SETUP = 2,
  parameter int unsigned TIMEOUT  = 1023
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       bus_init,
  input  logic [7:4] bus_br,
  input  logic       bus_npr,
  input  logic       bus_sack,
  input  logic       bus_bbsy,
  input  logic [7:5] cpu_prio,
  input  logic       cpu_br_ok,
  output logic [7:4] bus_bg_out,
  output logic       bus_npg_out,
  output logic       cpu_hold,
  output logic       grant_timeout
);

  localparam int unsigned SETUP_CYC  = (BG_SETUP == 0) ? 1 : BG_SETUP;
  localparam int unsigned SETUP_LAST = SETUP_CYC - 1;
  localparam int unsigned CNT_MAX    = (TIMEOUT > SETUP_LAST) ? TIMEOUT : SETUP_LAST;
  localparam int unsigned CW         = (CNT_MAX < 1) ? 1 : $clog2(CNT_MAX + 1);

  arb_state_t state, state_nxt;
  logic [2:0]    sel, sel_nxt;
  logic [CW-1:0] cnt, cnt_nxt, cnt_inc;
  logic [3:0]    bg_nxt;
  logic          npg_nxt, hold_nxt, tmo_nxt;
  logic          win_valid;
  logic [2:0]    win_sel;
  logic          live;

  unibus_prio_sel u_sel (
    .br        (bus_br),
    .npr       (bus_npr),
    .cpu_prio  (cpu_prio),
    .cpu_br_ok (cpu_br_ok),
    .valid     (win_valid),
    .sel       (win_sel)
  );

  assign live    = req_live(sel, bus_br, bus_npr);
  assign cnt_inc = (cnt == CW'(CNT_MAX)) ? cnt : cnt + 1'b1;

  always_comb begin
    state_nxt = state;
    sel_nxt   = sel;
    cnt_nxt   = cnt;
    bg_nxt    = '0;
    npg_nxt   = 1'b0;
    hold_nxt  = cpu_hold;
    tmo_nxt   = 1'b0;
    unique case (state)
      IDLE: begin
        hold_nxt = 1'b0;
        if (!bus_sack && win_valid) begin
          state_nxt = SETUP;
          sel_nxt   = win_sel;
          cnt_nxt   = '0;
          hold_nxt  = 1'b1;
        end
      end
      SETUP: begin
        if (!live) begin
          state_nxt = IDLE;
          hold_nxt  = 1'b0;
        end else if (cnt == CW'(SETUP_LAST)) begin
          // Grant register loads on the same edge the state enters GRANT.
          state_nxt = GRANT;
          cnt_nxt   = '0;
          if (sel == SEL_NPR) npg_nxt = 1'b1;
          else                bg_nxt  = grant_vec(sel);
        end else begin
          cnt_nxt = cnt_inc;
        end
      end
      GRANT: begin
        if (bus_sack) begin
          state_nxt = SACKED;
        end else if (!live) begin
          state_nxt = IDLE;
          hold_nxt  = 1'b0;
        end else if (cnt == CW'(TIMEOUT)) begin
          state_nxt = IDLE;
          hold_nxt  = 1'b0;
          tmo_nxt   = 1'b1;
        end else begin
          cnt_nxt = cnt_inc;
          if (sel == SEL_NPR) npg_nxt = 1'b1;
          else                bg_nxt  = grant_vec(sel);
        end
      end
      SACKED: begin
        if (bus_bbsy) begin
          state_nxt = MASTER;
        end else if (!bus_sack) begin
          state_nxt = IDLE;
          hold_nxt  = 1'b0;
        end
      end
      MASTER: begin
        if (!bus_bbsy && !bus_sack) begin
          state_nxt = IDLE;
          hold_nxt  = 1'b0;
        end
      end
      default: begin
        state_nxt = IDLE;
        hold_nxt  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      sel           <= SEL_NPR;
      cnt           <= '0;
      bus_bg_out    <= '0;
      bus_npg_out   <= 1'b0;
      cpu_hold      <= 1'b0;
      grant_timeout <= 1'b0;
    end else if (bus_init) begin
      state         <= IDLE;
      sel           <= SEL_NPR;
      cnt           <= '0;
      bus_bg_out    <= '0;
      bus_npg_out   <= 1'b0;
      cpu_hold      <= 1'b0;
      grant_timeout <= 1'b0;
    end else begin
      state         <= state_nxt;
      sel           <= sel_nxt;
      cnt           <= cnt_nxt;
      bus_bg_out    <= bg_nxt;
      bus_npg_out   <= npg_nxt;
      cpu_hold      <= hold_nxt;
      grant_timeout <= tmo_nxt;
    end
  end

endmodule

// File: tb/tb_unibus_arb.sv
// Directed scoreboard bench for unibus_arb (BG_SETUP=2, TIMEOUT=15) plus a BG_SETUP=0 latency probe.
module tb_unibus_arb;
  import unibus_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       bus_init;
  logic [7:4] bus_br;
  logic       bus_npr, bus_sack, bus_bbsy;
  logic [7:5] cpu_prio;
  logic       cpu_br_ok;
  logic [7:4] bus_bg_out, bg0;
  logic       bus_npg_out, cpu_hold, grant_timeout;
  logic       npg0, hold0, tmo0;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string      tag;
    logic [3:0] bg;
    logic       npg;
    logic       hold;
    logic       tmo;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  unibus_arb #(.BG_SETUP(2), .TIMEOUT(15)) u_dut (
    .clk(clk), .reset(reset), .bus_init(bus_init), .bus_br(bus_br), .bus_npr(bus_npr),
    .bus_sack(bus_sack), .bus_bbsy(bus_bbsy), .cpu_prio(cpu_prio), .cpu_br_ok(cpu_br_ok),
    .bus_bg_out(bus_bg_out), .bus_npg_out(bus_npg_out), .cpu_hold(cpu_hold),
    .grant_timeout(grant_timeout)
  );

  unibus_arb #(.BG_SETUP(0), .TIMEOUT(15)) u_dut0 (
    .clk(clk), .reset(reset), .bus_init(bus_init), .bus_br(bus_br), .bus_npr(bus_npr),
    .bus_sack(bus_sack), .bus_bbsy(bus_bbsy), .cpu_prio(cpu_prio), .cpu_br_ok(cpu_br_ok),
    .bus_bg_out(bg0), .bus_npg_out(npg0), .cpu_hold(hold0), .grant_timeout(tmo0)
  );

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] req);
    checks++;
    assert (obs === req) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, req);
    end
  endtask

  task automatic expect_out(input string tag, input logic [3:0] bg, input logic npg,
                            input logic hold, input logic tmo);
    exp_t e;
    e.tag = tag; e.bg = bg; e.npg = npg; e.hold = hold; e.tmo = tmo;
    sb.push_back(e);
  endtask

  task automatic cyc();
    exp_t e;
    @(posedge clk);
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check({e.tag, ".bg"},   bus_bg_out,    e.bg);
      check({e.tag, ".npg"},  {3'b0, bus_npg_out},   {3'b0, e.npg});
      check({e.tag, ".hold"}, {3'b0, cpu_hold},      {3'b0, e.hold});
      check({e.tag, ".tmo"},  {3'b0, grant_timeout}, {3'b0, e.tmo});
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b0; bus_init = 1'b0; bus_br = '0; bus_npr = 1'b0;
    bus_sack = 1'b0; bus_bbsy = 1'b0; cpu_prio = 3'd3; cpu_br_ok = 1'b1;
    @(posedge clk); #1;
    check("rst.bg", bus_bg_out, 4'h0);
    check("rst.hold", {3'b0, cpu_hold}, 4'h0);
    reset = 1'b1;
    expect_out("idle", 4'h0, 0, 0, 0); cyc();

    // BR4 grant after BG_SETUP+1 edges; higher BR7 during GRANT must not preempt.
    bus_br = 4'b0001;
    expect_out("t1_e0", 4'h0, 0, 1, 0); cyc();
    check("t1_dut0_e0", bg0, 4'h0);
    expect_out("t1_e1", 4'h0, 0, 1, 0); cyc();
    check("t1_dut0_lat2", bg0, 4'b0001);
    expect_out("t1_e2", 4'b0001, 0, 1, 0); cyc();
    bus_br = 4'b1001;
    expect_out("t1_nopreempt", 4'b0001, 0, 1, 0); cyc();
    bus_sack = 1'b1;
    expect_out("t1_sack", 4'h0, 0, 1, 0); cyc();
    bus_bbsy = 1'b1;
    expect_out("t1_master", 4'h0, 0, 1, 0); cyc();
    bus_sack = 1'b0; bus_br = '0;
    expect_out("t1_master2", 4'h0, 0, 1, 0); cyc();
    bus_bbsy = 1'b0;
    expect_out("t1_release", 4'h0, 0, 0, 0); cyc();

    // NPR beats BR7; BR7 follows after release, then withdraws in GRANT.
    cpu_prio = 3'd0; bus_npr = 1'b1; bus_br = 4'b1000;
    expect_out("t2_s0", 4'h0, 0, 1, 0); cyc();
    expect_out("t2_s1", 4'h0, 0, 1, 0); cyc();
    expect_out("t2_npg", 4'h0, 1, 1, 0); cyc();
    bus_sack = 1'b1; bus_npr = 1'b0;
    expect_out("t2_sack", 4'h0, 0, 1, 0); cyc();
    bus_bbsy = 1'b1; bus_sack = 1'b0;
    expect_out("t2_master", 4'h0, 0, 1, 0); cyc();
    bus_bbsy = 1'b0;
    expect_out("t2_release", 4'h0, 0, 0, 0); cyc();
    expect_out("t2_br7_s0", 4'h0, 0, 1, 0); cyc();
    expect_out("t2_br7_s1", 4'h0, 0, 1, 0); cyc();
    expect_out("t2_br7_bg", 4'b1000, 0, 1, 0); cyc();
    bus_br = '0;
    expect_out("t2_withdraw", 4'h0, 0, 0, 0); cyc();

    // BR5 masked at prio 5, granted at prio 4; prio rise / br_ok fall keep the grant.
    cpu_prio = 3'd5; bus_br = 4'b0010;
    expect_out("t3_mask0", 4'h0, 0, 0, 0); cyc();
    expect_out("t3_mask1", 4'h0, 0, 0, 0); cyc();
    cpu_prio = 3'd4;
    expect_out("t3_s0", 4'h0, 0, 1, 0); cyc();
    expect_out("t3_s1", 4'h0, 0, 1, 0); cyc();
    expect_out("t3_bg5", 4'b0010, 0, 1, 0); cyc();
    cpu_prio = 3'd7; cpu_br_ok = 1'b0;
    expect_out("t3_keep", 4'b0010, 0, 1, 0); cyc();
    bus_br = '0;
    expect_out("t3_drop", 4'h0, 0, 0, 0); cyc();
    cpu_prio = 3'd3; cpu_br_ok = 1'b1;

    // BR6 with no SACK: held 16 cycles, then a single timeout pulse.
    bus_br = 4'b0100;
    expect_out("t4_s0", 4'h0, 0, 1, 0); cyc();
    expect_out("t4_s1", 4'h0, 0, 1, 0); cyc();
    for (int i = 0; i < 16; i++) begin
      expect_out($sformatf("t4_held%0d", i), 4'b0100, 0, 1, 0); cyc();
    end
    expect_out("t4_timeout", 4'h0, 0, 0, 1); cyc();
    bus_br = '0;
    expect_out("t4_idle", 4'h0, 0, 0, 0); cyc();

    // Stale SACK in IDLE blocks selection.
    bus_sack = 1'b1; bus_br = 4'b0001;
    expect_out("t5_stale", 4'h0, 0, 0, 0); cyc();
    bus_sack = 1'b0; bus_br = '0;
    expect_out("t5_stale_end", 4'h0, 0, 0, 0); cyc();

    // BR4 withdrawn in SETUP, then in GRANT.
    bus_br = 4'b0001;
    expect_out("t5_s0", 4'h0, 0, 1, 0); cyc();
    bus_br = '0;
    expect_out("t5_setup_drop", 4'h0, 0, 0, 0); cyc();
    bus_br = 4'b0001;
    expect_out("t5_s0b", 4'h0, 0, 1, 0); cyc();
    expect_out("t5_s1b", 4'h0, 0, 1, 0); cyc();
    expect_out("t5_bg4", 4'b0001, 0, 1, 0); cyc();
    bus_br = '0;
    expect_out("t5_grant_drop", 4'h0, 0, 0, 0); cyc();

    // Async reset mid-GRANT, pending BR7 re-arbitrated, bus_init in MASTER.
    bus_br = 4'b1000;
    expect_out("t6_s0", 4'h0, 0, 1, 0); cyc();
    expect_out("t6_s1", 4'h0, 0, 1, 0); cyc();
    expect_out("t6_bg7", 4'b1000, 0, 1, 0); cyc();
    #2 reset = 1'b0;
    #1;
    check("t6_async_bg", bus_bg_out, 4'h0);
    check("t6_async_hold", {3'b0, cpu_hold}, 4'h0);
    @(posedge clk); #1;
    reset = 1'b1;
    expect_out("t6_re_s0", 4'h0, 0, 1, 0); cyc();
    expect_out("t6_re_s1", 4'h0, 0, 1, 0); cyc();
    expect_out("t6_re_bg7", 4'b1000, 0, 1, 0); cyc();
    bus_sack = 1'b1;
    expect_out("t6_sack", 4'h0, 0, 1, 0); cyc();
    bus_bbsy = 1'b1;
    expect_out("t6_master", 4'h0, 0, 1, 0); cyc();
    bus_init = 1'b1;
    expect_out("t6_init", 4'h0, 0, 0, 0); cyc();
    bus_init = 1'b0; bus_br = '0; bus_sack = 1'b0; bus_bbsy = 1'b0;
    expect_out("t6_after_init", 4'h0, 0, 0, 0); cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/unibus_arb.md
Name: unibus_arb

Overview:
- Bus-grant arbiter on the CPU side of the Unibus. Shares the bus between the CPU and the device interrupt controllers/DMA masters on BR7–BR4 and NPR.
- Samples the request lines, picks the winner by fixed priority and the processor priority level, and drives one BG/NPG daisy-chain line.
- Tracks the SACK/BBSY handshake until the new master releases the bus, and holds off new CPU cycles meanwhile.
- Feeds bus_bg_in of the device chain.

Parameters:
- BG_SETUP, 2: cycles a selected request must persist before the grant line is raised.
- TIMEOUT, 1023: max cycles a grant is held without SACK before passive release.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low; 0 = reset.
- bus_init  in  1  synchronous bus initialize; same effect as reset.
- bus_br  in  [7:4]  bus requests.
- bus_npr  in  1  non-processor request.
- bus_sack  in  1  selection acknowledge from the granted device.
- bus_bbsy  in  1  bus busy driven by devices (excludes the CPU).
- cpu_prio  in  [7:5]  processor status priority.
- cpu_br_ok  in  1  CPU at an instruction boundary; BR grants are allowed.
- bus_bg_out  out  [7:4]  bus grants, at most one high.
- bus_npg_out  out  1  NPR grant.
- cpu_hold  out  1  CPU must not start a new bus cycle.
- grant_timeout  out  1  one-cycle pulse on passive release by timeout.

Behaviour:
- All outputs are registered.
- Reset/bus_init: state IDLE, all grants 0, cpu_hold 0, grant_timeout 0, counters 0.
- bus_init beats every other event in the same cycle.
- Selection (combinational, evaluated only in IDLE with bus_sack=0):
  - bus_npr wins unconditionally.
  - Otherwise the highest L in 7..4 with bus_br[L]=1, L>cpu_prio and cpu_br_ok=1.
  - The winner is latched as sel (NPR or level 4–7).
- IDLE:
  - Winner exists -> SETUP, counter cleared, cpu_hold<=1.
  - bus_sack=1 in IDLE (stale acknowledge): no selection.
- SETUP:
  - Counter increments each cycle.
  - Latched request drops -> IDLE, cpu_hold<=0.
  - Counter reaches BG_SETUP-1 -> GRANT; the grant line for sel rises on the next clock edge. Request-to-grant latency = BG_SETUP+1 cycles.
  - BG_SETUP=0 is treated as 1.
- GRANT:
  - Exactly one of bus_bg_out[sel]/bus_npg_out is high; the counter counts from 0.
  - Priority within the cycle: bus_sack, then request withdrawal, then timeout.
  - bus_sack=1 -> grant drops next edge, go to SACKED.
  - Latched request drops without SACK -> grant drops, IDLE, cpu_hold 0.
  - Counter == TIMEOUT -> grant drops, grant_timeout pulses for one cycle, IDLE.
  - A higher request arriving during GRANT does not preempt.
  - A cpu_prio rise or cpu_br_ok fall during GRANT does not withdraw the grant.
- SACKED:
  - bus_bbsy=1 -> MASTER.
  - bus_sack drops while bus_bbsy=0 -> IDLE (device abandoned).
  - cpu_hold stays 1.
- MASTER:
  - bus_bbsy=0 and bus_sack=0 -> IDLE, cpu_hold<=0.
  - Re-arbitration can occur on the following cycle; there is no idle gap beyond that one cycle.
- Counter widths: the counter is $clog2(TIMEOUT+1) bits and saturates at TIMEOUT (no wrap).
- Async reset mid-GRANT: grant lines fall immediately, with no glitch to another line.

Decomposition:
- Shared package unibus_pkg:
  - state encoding: IDLE, SETUP, GRANT, SACKED, MASTER.
  - SEL_NPR code and BR level constants, reusable by future NPR devices and the CPU model.
- Sub-module unibus_prio_sel: combinational priority selector. Inputs: br, npr, cpu_prio, cpu_br_ok. Outputs: valid and sel.

Test Plan:
- bus_br[4]=1, cpu_prio=3, cpu_br_ok=1, BG_SETUP=2 -> bus_bg_out=4'b0001 exactly 3 cycles after request; on sack, bg drops the next cycle; bbsy 1 then 0 returns to IDLE and cpu_hold falls.
- bus_npr=1 and bus_br[7]=1 in the same cycle, cpu_prio=0 -> bus_npg_out=1, bus_bg_out=0; after release, BR7 is granted next.
- bus_br[5]=1 with cpu_prio=5 -> no grant, cpu_hold 0; lower cpu_prio to 4 -> bg[5] granted.
- Grant bg[6] and never assert SACK, TIMEOUT=15 -> grant held 16 cycles, then drops; grant_timeout pulses once; state is IDLE.
- Request bus_br[4] withdrawn during SETUP and again during GRANT -> no grant / grant dropped; cpu_hold back to 0 the next cycle.
- reset to 0 while bg[7] is high -> bg drops asynchronously; after release, the pending BR7 is re-arbitrated from IDLE. bus_init pulse in MASTER -> IDLE, all outputs 0.
